dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 (core load/store path) and port 1 (DMA/debug loader).
- Supports single and multi-beat bursts with auto-incrementing word addresses.
- Uses round-robin fairness and holds the grant for a whole burst.
- Drives the memory address, write-enable and write-data pins, and returns registered read data to the owning requester.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LW, 4, burst-length field width; a burst is len+1 beats, so at most 2^LW beats.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-low (0 = reset).
- r0_req, r1_req  in  1  transfer request; held high until the first grant.
- r0_we, r1_we  in  1  1 = write burst, 0 = read burst; sampled at acceptance.
- r0_addr, r1_addr  in  AW  burst start byte address, word aligned; sampled at acceptance.
- r0_len, r1_len  in  LW  beats minus 1; sampled at acceptance.
- r0_wd, r1_wd  in  DW  write data; must be valid in every cycle that the matching gnt is high.
- r0_gnt, r1_gnt  out  1  high during each beat cycle that this port owns the memory.
- r0_rvalid, r1_rvalid  out  1  read data valid, one cycle after each read beat.
- r0_rdata, r1_rdata  out  DW  registered read data.
- m_addr  out  AW  memory address.
- m_we  out  1  memory write enable.
- m_wd  out  DW  memory write data.
- m_rd  in  DW  memory read data, combinational from m_addr.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- States: IDLE, OWN0, OWN1.
- Registers:
  - state
  - last_owner, 1 bit
  - base, AW bits
  - beat and len_q, LW bits each
  - we_q
  - rvalid/rdata per port
- Reset (arst=0, immediate):
  - state=IDLE, last_owner=1 (port 0 wins first tie), all counters and latches = 0.
  - All gnt/rvalid/rdata/m_* outputs = 0; busy=0.
  - A burst in progress is abandoned and no memory write occurs once reset is asserted.
- Arbitration, evaluated in IDLE and on the last beat of a burst:
  - If only one port requests, that port is chosen.
  - If both request, the port != last_owner is chosen.
  - If none request, the next state is IDLE.
- Acceptance of port x at a clock edge:
  - base←rx_addr, len_q←rx_len, we_q←rx_we, beat←0, state←OWNx, last_owner←x.
- Request-to-first-beat latency:
  - req high in IDLE during cycle N means gnt high in cycle N+1.
  - A read beat in cycle N+1 gives rvalid in cycle N+2.
- In OWNx, combinational outputs:
  - gnt_x=1, other gnt=0.
  - m_addr = base + (beat<<2), modulo 2^AW; wrap from 0xFFFFFFFC to 0x00000000 is allowed.
  - m_we = we_q.
  - m_wd = rx_wd.
- Each OWNx cycle is one beat.
  - If beat != len_q: beat←beat+1.
  - If beat == len_q (last beat): re-arbitrate, excluding nothing. This allows back-to-back handover to the other port with no IDLE bubble, or a re-grant of the same port if only it requests.
- Read return: on a read beat of port x, rx_rdata←m_rd and rx_rvalid←1 at the next edge. Otherwise rx_rvalid←0 and rx_rdata holds its value.
- Deasserting req during a burst is ignored; the burst always completes len_q+1 beats.
- Changes to rx_addr/rx_len/rx_we after acceptance are ignored.
- In IDLE: m_we=0, m_addr=0, m_wd=0, both gnt=0.
- No combinational path from rx_req to m_we. m_we depends only on registered state and we_q.

Test Plan:
- Port 0 single read at 0x100, len=0, mem[0x100]=0xDEADBEEF:
  - Required: gnt0 high exactly 1 cycle, then r0_rvalid=1 with r0_rdata=0xDEADBEEF the next cycle.
  - Required: busy returns to 0.
- Port 1 write burst at 0x40, len=3, wd=0x11,0x22,0x33,0x44 over its 4 gnt cycles:
  - Required: m_addr=0x40,0x44,0x48,0x4C with m_we=1 on each beat.
  - Required: memory then reads back those values.
- Both ports request in the same IDLE cycle right after reset, each len=1:
  - Required: port 0 is granted 2 cycles, then port 1 is granted 2 cycles with no gap, then IDLE.
- Port 0 holds req high continuously (len=0) while port 1 requests repeatedly:
  - Required: grants alternate 0,1,0,1.
  - Required: no port is granted twice in a row while the other is waiting.
- Port 0 read burst at 0xFFFFFFF8, len=2:
  - Required: m_addr=0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
  - Required: three r0_rvalid pulses on consecutive cycles.
- Assert arst=0 on beat 2 of a 4-beat port-1 write:
  - Required: m_we, gnt and busy drop to 0 immediately, and no further memory write occurs.
  - Required: after release, a simultaneous request from both ports grants port 0 first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bundle for the data-memory arbiter.
// slave is the arbiter's view, master the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 4
);
  logic          r0_req;
  logic          r1_req;
  logic          r0_we;
  logic          r1_we;
  logic [AW-1:0] r0_addr;
  logic [AW-1:0] r1_addr;
  logic [LW-1:0] r0_len;
  logic [LW-1:0] r1_len;
  logic [DW-1:0] r0_wd;
  logic [DW-1:0] r1_wd;
  logic          r0_gnt;
  logic          r1_gnt;
  logic          r0_rvalid;
  logic          r1_rvalid;
  logic [DW-1:0] r0_rdata;
  logic [DW-1:0] r1_rdata;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;
  logic          busy;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we,
    input  r0_addr, r1_addr, r0_len, r1_len,
    input  r0_wd, r1_wd, m_rd,
    output r0_gnt, r1_gnt,
    output r0_rvalid, r1_rvalid,
    output r0_rdata, r1_rdata,
    output m_addr, m_we, m_wd, busy
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we,
    output r0_addr, r1_addr, r0_len, r1_len,
    output r0_wd, r1_wd, m_rd,
    input  r0_gnt, r1_gnt,
    input  r0_rvalid, r1_rvalid,
    input  r0_rdata, r1_rdata,
    input  m_addr, m_we, m_wd, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin burst arbiter for the single-port data memory.
// Grant is held for a whole burst; handover happens on the last beat.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input logic           clk,
  input logic           arst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          last_owner;
  logic [AW-1:0] base;
  logic [LW-1:0] beat;
  logic [LW-1:0] len_q;
  logic          we_q;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  logic own;
  logic last;
  logic arb;
  logic take;
  logic pick;

  assign own  = (state != IDLE);
  assign last = own && (beat == len_q);
  assign arb  = !own || last;

  always_comb begin
    state_n = state;
    take    = 1'b0;
    pick    = last_owner;
    if (arb) begin
      if (bus.r0_req && bus.r1_req) begin
        take = 1'b1;
        pick = !last_owner;
      end else if (bus.r0_req) begin
        take = 1'b1;
        pick = 1'b0;
      end else if (bus.r1_req) begin
        take = 1'b1;
        pick = 1'b1;
      end
      if (take) state_n = pick ? OWN1 : OWN0;
      else      state_n = IDLE;
    end
  end

  // Memory pins come only from registered state, never from req.
  always_comb begin
    bus.r0_gnt = (state == OWN0);
    bus.r1_gnt = (state == OWN1);
    bus.m_we   = own && we_q;
    bus.m_addr = '0;
    bus.m_wd   = '0;
    if (own) bus.m_addr = base + AW'({beat, 2'b00});
    if (state == OWN0) bus.m_wd = bus.r0_wd;
    if (state == OWN1) bus.m_wd = bus.r1_wd;
  end

  assign bus.busy      = own;
  assign bus.r0_rvalid = rvalid0;
  assign bus.r1_rvalid = rvalid1;
  assign bus.r0_rdata  = rdata0;
  assign bus.r1_rdata  = rdata1;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      base       <= '0;
      beat       <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        base       <= pick ? bus.r1_addr : bus.r0_addr;
        len_q      <= pick ? bus.r1_len : bus.r0_len;
        we_q       <= pick ? bus.r1_we : bus.r0_we;
        beat       <= '0;
        last_owner <= pick;
      end else if (own && !last) begin
        beat <= beat + 1'b1;
      end
      rvalid0 <= (state == OWN0) && !we_q;
      rvalid1 <= (state == OWN1) && !we_q;
      if ((state == OWN0) && !we_q) rdata0 <= bus.m_rd;
      if ((state == OWN1) && !we_q) rdata1 <= bus.m_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected beats and read data
// are queued with the stimulus and popped as the DUT produces them.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic        we;
  } beat_t;

  bit   [31:0] mem [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  int          wcount = 0;

  beat_t       beat_q[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int          vectors = 0;
  int          miscompares = 0;

  assign bus.m_rd  = mem[bus.m_addr[9:2]];
  assign bus.r0_wd = 32'hA000_0000 | bus.m_addr;
  assign bus.r1_wd = 32'h11 * ({28'd0, bus.m_addr[5:2]} + 32'd1);

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end else if (bus.m_we) begin
      mem[bus.m_addr[9:2]] <= bus.m_wd;
      wcount <= wcount + 1;
    end
  end

  // Scoreboard: every grant cycle and rvalid pulse must match the queue head.
  always @(negedge clk) begin
    beat_t       e;
    logic [31:0] d;
    logic [31:0] wd;
    if (bus.r0_gnt || bus.r1_gnt) begin
      vectors++;
      if (beat_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: unexpected grant g0=%0b g1=%0b addr=%h",
                 bus.r0_gnt, bus.r1_gnt, bus.m_addr);
      end else begin
        e  = beat_q.pop_front();
        wd = e.port ? 32'h11 * ({28'd0, e.addr[5:2]} + 32'd1)
                    : (32'hA000_0000 | e.addr);
        if (bus.r1_gnt !== e.port || bus.r0_gnt !== !e.port ||
            bus.m_addr !== e.addr || bus.m_we !== e.we ||
            (e.we && bus.m_wd !== wd)) begin
          miscompares++;
          $display("FAIL beat: got g1=%0b addr=%h we=%0b wd=%h, required g1=%0b addr=%h we=%0b wd=%h",
                   bus.r1_gnt, bus.m_addr, bus.m_we, bus.m_wd,
                   e.port, e.addr, e.we, wd);
        end
      end
    end
    if (bus.r0_rvalid) begin
      vectors++;
      if (rq0.size() == 0) begin
        miscompares++;
        $display("FAIL rdata0: unexpected rvalid data=%h", bus.r0_rdata);
      end else begin
        d = rq0.pop_front();
        if (bus.r0_rdata !== d) begin
          miscompares++;
          $display("FAIL rdata0: got %h required %h", bus.r0_rdata, d);
        end
      end
    end
    if (bus.r1_rvalid) begin
      vectors++;
      if (rq1.size() == 0) begin
        miscompares++;
        $display("FAIL rdata1: unexpected rvalid data=%h", bus.r1_rdata);
      end else begin
        d = rq1.pop_front();
        if (bus.r1_rdata !== d) begin
          miscompares++;
          $display("FAIL rdata1: got %h required %h", bus.r1_rdata, d);
        end
      end
    end
  end

  task automatic exp_beat(input bit p, input logic [31:0] a, input bit w);
    beat_q.push_back({p, a, w});
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] data);
    ld_idx  = idx;
    ld_data = data;
    ld_en   = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic request(input bit port, input logic [31:0] addr,
                         input logic [3:0] len, input bit we);
    bit got = 1'b0;
    if (port) begin
      bus.r1_addr = addr;
      bus.r1_len  = len;
      bus.r1_we   = we;
      bus.r1_req  = 1'b1;
    end else begin
      bus.r0_addr = addr;
      bus.r0_len  = len;
      bus.r0_we   = we;
      bus.r0_req  = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? bus.r1_gnt : bus.r0_gnt;
    end
    if (port) bus.r1_req = 1'b0;
    else      bus.r0_req = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL req_timeout port%0d: got no grant, required grant", port);
    end
  endtask

  task automatic drain(input string name);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || beat_q.size() != 0 ||
        rq0.size() != 0 || rq1.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: busy=%0b beats=%0d rq0=%0d rq1=%0d, required all 0",
               name, bus.busy, beat_q.size(), rq0.size(), rq1.size());
      beat_q.delete();
      rq0.delete();
      rq1.delete();
    end
  endtask

  task automatic test_reset();
    bus.r0_req = 0; bus.r1_req = 0;
    bus.r0_we = 0; bus.r1_we = 0;
    bus.r0_addr = 0; bus.r1_addr = 0;
    bus.r0_len = 0; bus.r1_len = 0;
    arst = 1'b1;
    #2 arst = 1'b0;
    load(8'h40, 32'hDEAD_BEEF);
    load(8'hFE, 32'h0000_00A1);
    load(8'hFF, 32'h0000_00A2);
    load(8'h00, 32'h0000_00A3);
    @(negedge clk);
    vectors++;
    if ({bus.r0_gnt, bus.r1_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_gnt: got %b required 00", {bus.r0_gnt, bus.r1_gnt});
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy: got %b required 0", bus.busy);
    end
    vectors++;
    if (bus.m_we !== 1'b0 || bus.m_addr !== '0 || bus.m_wd !== '0) begin
      miscompares++;
      $display("FAIL rst_mem: got we=%b addr=%h wd=%h required 0",
               bus.m_we, bus.m_addr, bus.m_wd);
    end
    vectors++;
    if ({bus.r0_rvalid, bus.r1_rvalid} !== 2'b00 ||
        bus.r0_rdata !== '0 || bus.r1_rdata !== '0) begin
      miscompares++;
      $display("FAIL rst_rd: got rv=%b d0=%h d1=%h required 0",
               {bus.r0_rvalid, bus.r1_rvalid}, bus.r0_rdata, bus.r1_rdata);
    end
    arst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_read();
    exp_beat(0, 32'h100, 0);
    rq0.push_back(32'hDEAD_BEEF);
    request(0, 32'h100, 4'd0, 1'b0);
    drain("single_read");
  endtask

  task automatic test_write_burst();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) exp_beat(1, 32'h40 + 32'(4 * k), 1);
    request(1, 32'h40, 4'd3, 1'b1);
    drain("write_burst");
    for (int k = 0; k < 4; k++) begin
      v = 32'h11 * 32'(k + 1);
      vectors++;
      if (mem[16 + k] !== v) begin
        miscompares++;
        $display("FAIL wr_mem%0d: got %h required %h", k, mem[16 + k], v);
      end
    end
    for (int k = 0; k < 4; k++) begin
      exp_beat(0, 32'h40 + 32'(4 * k), 0);
      rq0.push_back(32'h11 * 32'(k + 1));
    end
    request(0, 32'h40, 4'd3, 1'b0);
    drain("read_back");
  endtask

  task automatic test_both();
    logic [1:0] pat [6];
    pat = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    arst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    exp_beat(0, 32'h200, 1);
    exp_beat(0, 32'h204, 1);
    exp_beat(1, 32'h300, 1);
    exp_beat(1, 32'h304, 1);
    bus.r0_addr = 32'h200; bus.r0_len = 4'd1; bus.r0_we = 1'b1;
    bus.r1_addr = 32'h300; bus.r1_len = 4'd1; bus.r1_we = 1'b1;
    bus.r0_req = 1'b1;
    bus.r1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.r1_gnt, bus.r0_gnt} !== pat[i]) begin
        miscompares++;
        $display("FAIL both_cyc%0d: got g1g0=%b required %b",
                 i, {bus.r1_gnt, bus.r0_gnt}, pat[i]);
      end
      if (bus.r0_gnt) bus.r0_req = 1'b0;
      if (bus.r1_gnt) bus.r1_req = 1'b0;
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    drain("both");
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    for (int k = 0; k < 4; k++) begin
      exp_beat(0, 32'h100, 0);
      exp_beat(1, 32'h104, 0);
      rq0.push_back(32'hDEAD_BEEF);
      rq1.push_back(32'h0);
    end
    bus.r0_addr = 32'h100; bus.r0_len = 4'd0; bus.r0_we = 1'b0;
    bus.r1_addr = 32'h104; bus.r1_len = 4'd0; bus.r1_we = 1'b0;
    bus.r0_req = 1'b1;
    bus.r1_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      want = (i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b01 : 2'b10;
      vectors++;
      if ({bus.r1_gnt, bus.r0_gnt} !== want) begin
        miscompares++;
        $display("FAIL alt_cyc%0d: got g1g0=%b required %b",
                 i, {bus.r1_gnt, bus.r0_gnt}, want);
      end
      bus.r1_req = !bus.r1_gnt;
      if (i == 8) begin
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
      end
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    drain("alternate");
  endtask

  task automatic test_wrap();
    exp_beat(0, 32'hFFFF_FFF8, 0);
    exp_beat(0, 32'hFFFF_FFFC, 0);
    exp_beat(0, 32'h0000_0000, 0);
    rq0.push_back(32'hA1);
    rq0.push_back(32'hA2);
    rq0.push_back(32'hA3);
    request(0, 32'hFFFF_FFF8, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.r0_rvalid !== (i < 3)) begin
        miscompares++;
        $display("FAIL wrap_rvalid%0d: got %b required %b",
                 i, bus.r0_rvalid, (i < 3));
      end
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    int wsnap;
    exp_beat(1, 32'h80, 1);
    exp_beat(1, 32'h84, 1);
    bus.r1_addr = 32'h80; bus.r1_len = 4'd3; bus.r1_we = 1'b1;
    bus.r1_req = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.r1_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_gnt: got %b required 1", bus.r1_gnt);
    end
    bus.r1_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    #1;
    vectors++;
    if (bus.m_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_we: got %b required 0", bus.m_we);
    end
    vectors++;
    if (bus.r1_gnt !== 1'b0 || bus.r0_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_gnt_drop: got %b%b required 00",
               bus.r1_gnt, bus.r0_gnt);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_busy: got %b required 0", bus.busy);
    end
    wsnap = wcount;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (wcount !== wsnap || mem[34] !== 32'h0 || mem[35] !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_nowrite: got writes=%0d m88=%h m8c=%h required %0d 0 0",
               wcount, mem[34], mem[35], wsnap);
    end
    vectors++;
    if (mem[32] !== 32'h11 || mem[33] !== 32'h22) begin
      miscompares++;
      $display("FAIL rmid_pre: got %h %h required 11 22", mem[32], mem[33]);
    end
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    exp_beat(0, 32'h100, 0);
    exp_beat(1, 32'h104, 0);
    rq0.push_back(32'hDEAD_BEEF);
    rq1.push_back(32'h0);
    fork
      request(0, 32'h100, 4'd0, 1'b0);
      request(1, 32'h104, 4'd0, 1'b0);
    join
    drain("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_both();
    test_alternate();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
